mult_div_sequencer: RTL and testbench

Multi-cycle controller that executes unsigned 32×32 multiply (MULTU) and divide (DIVU) by time-sharing the processor's 32-bit ALU.
- While busy it owns the ALU operand/operation inputs through `alu_req`; the top level muxes these ahead of the normal decode path.
- It sequences one ADD (multiply) or SUB (divide) per cycle for 32 iterations.
- Results land in internal HI/LO registers for MFHI/MFLO.

---
 rtl/mult_div_sequencer.sv | 136 +++++++++++++
 tb/tb_mult_div_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the shared 32-bit ALU for one
// add (shift-add multiply) or subtract (restoring divide) per cycle over 32 iterations.
module mult_div_sequencer #(
  parameter logic [3:0] ALU_ADD = 4'b0011,
  parameter logic [3:0] ALU_SUB = 4'b0100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_div_by_zero,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_alu_req,
  output logic [3:0]  o_alu_operation,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [4:0]  o_alu_shamt,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_zero
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic [31:0] r_opnd, w_opnd_d;
  logic [4:0]  r_count, w_count_d;
  logic        r_dbz, w_dbz_d;

  logic [31:0] w_sum;
  logic        w_carry;
  logic [31:0] w_shifted;
  logic        w_div_take;
  logic        w_unused;

  assign w_unused = i_alu_zero;

  // The ALU has no carry-out port, so overflow is detected as a wrapped sum.
  assign w_sum   = r_lo[0] ? i_alu_result : r_hi;
  assign w_carry = r_lo[0] & (i_alu_result < r_hi);

  // hi[31] is the 33rd bit of the shifted partial remainder.
  assign w_shifted  = {r_hi[30:0], r_lo[31]};
  assign w_div_take = r_hi[31] | (w_shifted >= r_opnd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
      r_count <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_opnd  <= w_opnd_d;
      r_count <= w_count_d;
      r_dbz   <= w_dbz_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_hi_d          = r_hi;
    w_lo_d          = r_lo;
    w_opnd_d        = r_opnd;
    w_count_d       = r_count;
    w_dbz_d         = r_dbz;
    o_alu_req       = 1'b0;
    o_alu_operation = '0;
    o_alu_a         = '0;
    o_alu_b         = '0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_dbz_d   = 1'b0;
          w_count_d = '0;
          if (!i_op) begin
            w_hi_d    = '0;
            w_lo_d    = i_rt_data;
            w_opnd_d  = i_rs_data;
            w_state_d = StMul;
          end else if (i_rt_data != '0) begin
            w_hi_d    = '0;
            w_lo_d    = i_rs_data;
            w_opnd_d  = i_rt_data;
            w_state_d = StDiv;
          end else begin
            w_hi_d    = i_rs_data;
            w_lo_d    = '1;
            w_dbz_d   = 1'b1;
            w_state_d = StDone;
          end
        end
      end
      StMul: begin
        o_alu_req       = 1'b1;
        o_alu_operation = ALU_ADD;
        o_alu_a         = r_hi;
        o_alu_b         = r_opnd;
        w_hi_d          = {w_carry, w_sum[31:1]};
        w_lo_d          = {w_sum[0], r_lo[31:1]};
        w_count_d       = r_count + 5'd1;
        if (r_count == 5'd31) w_state_d = StDone;
      end
      StDiv: begin
        o_alu_req       = 1'b1;
        o_alu_operation = ALU_SUB;
        o_alu_a         = w_shifted;
        o_alu_b         = r_opnd;
        w_hi_d          = w_div_take ? i_alu_result : w_shifted;
        w_lo_d          = {r_lo[30:0], w_div_take};
        w_count_d       = r_count + 5'd1;
        if (r_count == 5'd31) w_state_d = StDone;
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign o_busy        = (r_state != StIdle);
  assign o_done        = (r_state == StDone);
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_alu_shamt   = '0;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Scoreboard bench for mult_div_sequencer: directed cases plus random MULTU/DIVU
// checked against plain 64-bit multiply and integer divide/modulo.
module tb_mult_div_sequencer;

  localparam logic [3:0] OpAdd = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done, dbz, alu_req, alu_zero;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [3:0]  alu_operation;
  logic [4:0]  alu_shamt;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          act_lo = 0;
  int          act_hi = -1;
  logic [3:0]  exp_alu_op = '0;

  mult_div_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_op           (op),
    .i_rs_data      (rs_data),
    .i_rt_data      (rt_data),
    .o_busy         (busy),
    .o_done         (done),
    .o_div_by_zero  (dbz),
    .o_hi           (hi),
    .o_lo           (lo),
    .o_alu_req      (alu_req),
    .o_alu_operation(alu_operation),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_shamt    (alu_shamt),
    .i_alu_result   (alu_result),
    .i_alu_zero     (alu_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU model
  always_comb begin
    alu_result = '0;
    if (alu_operation == OpAdd) alu_result = alu_a + alu_b;
    else if (alu_operation == OpSub) alu_result = alu_a - alu_b;
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_model(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e.cyc = 0;
    e.dbz = 1'b0;
    if (!o) begin
      p    = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else begin
      e.hi = a % b;
      e.lo = a / b;
    end
    return e;
  endfunction

  // Drive inputs now; the next rising edge accepts them.
  task automatic issue_now(input logic o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    e     = ref_model(o, a, b);
    e.cyc = cyc + (e.dbz ? 0 : 32);
    sb.push_back(e);
    act_lo     = cyc;
    act_hi     = e.cyc;
    exp_alu_op = e.dbz ? 4'b0000 : (o ? OpSub : OpAdd);
  endtask

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    issue_now(o, a, b);
  endtask

  // A start the DUT must ignore: nothing is pushed.
  task automatic poke();
    @(negedge clk);
    start   = 1'b1;
    op      = 1'($urandom_range(0, 1));
    rs_data = $urandom;
    rt_data = 32'($urandom_range(0, 3));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_done: got no done within 40 cycles, required done (cycle %0d)", cyc);
  endtask

  // Monitor: scoreboard pop on done, per-cycle busy and ALU-ownership checks.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("busy", 64'(busy), 64'((cyc >= act_lo) && (cyc <= act_hi)));
      if (alu_req) begin
        chk("alu_operation", 64'(alu_operation), 64'(exp_alu_op));
        chk("alu_shamt", 64'(alu_shamt), 64'd0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_by_zero", 64'(dbz), 64'(e.dbz));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_dbz"}, 64'(dbz), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'd0);
    chk({tag, "_lo"}, 64'(lo), 64'd0);
    chk({tag, "_alu_req"}, 64'(alu_req), 64'd0);
    chk({tag, "_alu_op"}, 64'(alu_operation), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
  endtask

  initial begin
    logic        o;
    logic [31:0] a, b;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 32'd7, 32'd6);
    wait_done();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    issue(1'b1, 32'd100, 32'd7);
    wait_done();
    issue(1'b1, 32'h8000_0000, 32'd3);
    wait_done();
    issue(1'b1, 32'h1234_5678, 32'd0);
    wait_done();

    // Starts mid-MULTU are ignored.
    issue(1'b0, 32'hDEAD_BEEF, 32'h0001_0003);
    repeat (4) @(posedge clk);
    poke();
    repeat (14) @(posedge clk);
    poke();
    wait_done();
    // Start held from the DONE cycle: ignored there, accepted in the following IDLE cycle.
    start   = 1'b1;
    op      = 1'b1;
    rs_data = 32'd1000;
    rt_data = 32'd33;
    @(posedge clk);
    issue_now(1'b1, 32'd1000, 32'd33);
    wait_done();

    // Asynchronous reset in the middle of a DIVU.
    issue(1'b1, 32'hCAFE_F00D, 32'd77);
    repeat (16) @(posedge clk);
    #2;
    act_hi = -1;
    sb.delete();
    rst_n  = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'd3, 32'd5);
    wait_done();

    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      if (o && ($urandom_range(0, 7) == 0)) b = '0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      else b = $urandom;
      issue(o, a, b);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
